// File: rtl/bcd_display_scanner.sv
// Five-digit multiplexed 7-segment scanner for the BCD adder result (carry shown as digit 4).
// A shadow register and pending flag hold new values until the frame wraps, so a frame never tears.
module bcd_display_scanner #(
    parameter int PRESCALE = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] sum_i,
    input  logic        cout_i,
    input  logic        blank_en_i,
    output logic [6:0]  seg_o,
    output logic [4:0]  an_o,
    output logic        frame_o,
    output logic        err_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [16:0]   shadow;
    logic [16:0]   disp;
    logic          pending;

    logic          tick;
    logic          boundary;
    logic [3:0]    nib;
    logic          upper_zero;
    logic          blank_slot;
    logic          invalid;

    assign tick     = (cnt == CW'(PRESCALE - 1));
    assign boundary = tick && (idx == 3'd4);

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // upper_zero: this digit and every digit above it are zero (digit 0 never qualifies)
    always_comb begin
        nib        = 4'd0;
        upper_zero = 1'b0;
        case (idx)
            3'd0: nib = disp[3:0];
            3'd1: begin nib = disp[7:4];   upper_zero = (disp[16:4]  == 13'd0); end
            3'd2: begin nib = disp[11:8];  upper_zero = (disp[16:8]  == 9'd0);  end
            3'd3: begin nib = disp[15:12]; upper_zero = (disp[16:12] == 5'd0);  end
            3'd4: begin nib = {3'b000, disp[16]}; upper_zero = !disp[16]; end
            default: ;
        endcase
    end

    assign blank_slot = blank_en_i && upper_zero;
    assign invalid    = (disp[3:0] > 4'd9) || (disp[7:4] > 4'd9) ||
                        (disp[11:8] > 4'd9) || (disp[15:12] > 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= 3'd0;
            shadow  <= 17'd0;
            disp    <= 17'd0;
            pending <= 1'b0;
            seg_o   <= 7'h00;
            an_o    <= 5'b11111;
            frame_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;

            // a load landing on the wrap edge bypasses the shadow straight into the frame
            if (load_i) begin
                shadow <= {cout_i, sum_i};
                if (boundary) begin
                    disp    <= {cout_i, sum_i};
                    pending <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end else if (boundary && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
            end

            frame_o <= boundary;
            err_o   <= invalid;
            if (blank_slot) begin
                seg_o <= 7'h00;
                an_o  <= 5'b11111;
            end else begin
                seg_o <= decode(nib);
                an_o  <= ~(5'b00001 << idx);
            end
        end
    end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed 7-segment display driver placed directly downstream of the 4-digit BCD adder. It captures the adder's 16-bit BCD sum and carry-out as a 5-digit value, with the carry as the top digit. It then scans the digits one at a time onto a common segment bus with per-digit anode enables. A shadow buffer keeps the display from tearing mid-frame, and the block also provides leading-zero blanking and invalid-digit flagging.

## Interface
- PRESCALE, 1000: clock cycles each digit slot is held; legal range ≥ 1.
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_i  in  1  capture strobe; samples sum_i/cout_i on the same edge.
- sum_i  in  16  4 BCD digits from the adder, digit 0 = sum_i[3:0].
- cout_i  in  1  adder carry-out, displayed as digit 4 ("0" or "1").
- blank_en_i  in  1  leading-zero blanking enable (level, sampled every cycle).
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- an_o  out  5  digit enables, one-hot active-low, bit k = digit k, registered.
- frame_o  out  1  one-cycle pulse at each frame boundary (digit 4 → 0 wrap).
- err_o  out  1  high while the displayed value has any nibble > 9, registered.

## Operation
- Shadow register (17 bits) plus a pending flag. On load_i the shadow register takes {cout_i, sum_i} and pending is set.
- Display register (17 bits) holds the value currently shown. It changes only at a frame boundary.
- Prescaler: counts 0..PRESCALE-1 and wraps to 0. tick = (count == PRESCALE-1). With PRESCALE = 1, tick is high every cycle.
- Digit index idx: 0..4. It advances on tick and wraps 4 → 0.
- A frame boundary is a tick while idx == 4. On a frame boundary:
  - frame_o pulses.
  - If pending, the display register takes the shadow value and pending clears.
- Simultaneous load_i and frame boundary: the incoming {cout_i, sum_i} goes straight to the display register, the shadow register is updated too, and pending stays 0. Load wins.
- A load_i while pending is already set overwrites the shadow value; only the last value is shown.
- Digit decode, for nibbles 0-9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
- Nibbles 10-15 display a dash, 40 (segment g only).
- Digit 4 displays 06 when the carry is 1 and 3F when it is 0.
- Blanking: when blank_en_i = 1, digit k (k = 1..4) is blanked if it and every higher digit are zero. Digit 0 is never blanked.
- A blanked slot drives an_o = 11111 and seg_o = 00.
- err_o = OR over the four display-register nibbles of (nibble > 9).

## Timing
- Reset values while rst_n = 0:
  - Prescaler, idx, shadow, display and pending are 0.
  - seg_o = 00, an_o = 11111, frame_o = 0, err_o = 0.
- Reset takes effect immediately (asynchronous). Reset mid-frame or with pending set discards everything; scanning restarts at digit 0.
- seg_o/an_o are registered from the current idx and display register: one cycle of latency from an idx change.
- First rising edge after rst_n deasserts: seg_o = 3F, an_o = 11110 (digit 0 showing "0").
- Each digit is shown for exactly PRESCALE cycles; a full frame is 5 × PRESCALE cycles.
- frame_o is high in the cycle after the wrap edge, aligned with the new display register value.
- Display-register update on a frame boundary:
  - seg_o reflects the new value from the first digit-0 slot.
  - err_o updates one cycle after the display-register update.
- Load-to-display latency: at most 5 × PRESCALE + 1 cycles.
- No tearing: all 5 digits of any frame come from one display-register value.

## Test plan
- Reset and scan (PRESCALE = 4):
  - Stimulus: release reset, blank_en_i = 0, no load.
  - Required: an_o sequences 11110, 11101, 11011, 10111, 01111 with 4 cycles each and seg_o = 3F throughout. frame_o pulses once every 20 cycles.
- Load and frame alignment:
  - Stimulus: load_i with sum_i = 1234h and cout_i = 1 mid-frame (idx = 2).
  - Required: the current frame still shows 0s. The next frame shows digits 0-4 as 66, 4F, 5B, 06, 06.
- Blanking:
  - Stimulus: blank_en_i = 1, value 0042h with cout = 0.
  - Required: digit 0 = 5B, digit 1 = 66, digits 2-4 have an_o = 11111 and seg_o = 00.
  - Stimulus: value 0000h with cout = 0.
  - Required: only digit 0 is lit, showing 3F.
- Invalid digit:
  - Stimulus: load sum_i = 0A09h.
  - Required: after the frame boundary, digit 2 shows 40, err_o = 1 one cycle after the display update, and err_o clears once 0009h is displayed.
- Collision and overwrite:
  - Stimulus: load 1111h, then load 2222h before the boundary.
  - Required: 2222h is displayed.
  - Stimulus: a load_i coinciding exactly with the boundary tick.
  - Required: the value appears in that new frame and pending = 0.
- Reset mid-operation:
  - Stimulus: assert rst_n low at idx = 3 with pending set.
  - Required: outputs go to their reset values at once, and after release the display shows 0s, not the pending value.
